// File: rtl/ddr_phy_pkg.sv
// Shared types and constants for the DDR PHY read-path controllers.
package ddr_phy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_SLIP,
    ST_LOCKED,
    ST_FAIL
  } bitslip_state_e;

  localparam logic [7:0] TRAIN_PATTERN_DEFAULT = 8'h0F;

  // Minimum of one bit so a degenerate count of 1 still yields a legal vector.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/ddr_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module ddr_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  // NOTE: reset is sampled on the clock edge only, so it sits inside the clocked branch, not the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ddr_rd_bitslip_ctrl.sv
// Read word-alignment controller for one DQ lane: slips the deserializer
// until the training pattern is seen MATCH_COUNT times in a row.
module ddr_rd_bitslip_ctrl
  import ddr_phy_pkg::*;
#(
  parameter int                DATA_W        = 8,
  parameter logic [DATA_W-1:0] TRAIN_PATTERN = DATA_W'(TRAIN_PATTERN_DEFAULT),
  parameter int                SETTLE_CYCLES = 8,
  parameter int                MATCH_COUNT   = 16,
  parameter int                MAX_SLIP      = 8,
  parameter int                ERR_W         = 8
) (
  input  logic                       gsclk_il,
  input  logic                       rst,
  input  logic                       start,
  input  logic [DATA_W-1:0]          q,
  input  logic                       q_valid,
  input  logic                       track_en,
  output logic                       align_il,
  output logic                       busy,
  output logic                       locked,
  output logic                       fail,
  output logic [clog2(MAX_SLIP)-1:0] slip_cnt,
  output logic [ERR_W-1:0]           err_cnt
);

  localparam int SLIP_W   = clog2(MAX_SLIP);
  localparam int SETTLE_W = clog2(SETTLE_CYCLES);
  localparam int MATCH_W  = clog2(MATCH_COUNT);

  localparam logic [SLIP_W-1:0]   SLIP_LAST   = SLIP_W'(MAX_SLIP - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [MATCH_W-1:0]  MATCH_LAST  = MATCH_W'(MATCH_COUNT - 1);

  bitslip_state_e      state_q;
  logic [SETTLE_W-1:0] settle_q;
  logic [MATCH_W-1:0]  match_q;
  logic [SLIP_W-1:0]   slip_q;
  logic                align_q;
  logic                locked_q;
  logic                fail_q;

  logic start_ok;
  logic word_match;
  logic err_inc;

  // A new run may only be launched from a resting state; start while busy is dropped.
  assign start_ok   = start && (state_q inside {ST_IDLE, ST_LOCKED, ST_FAIL});
  assign word_match = (q == TRAIN_PATTERN);
  assign err_inc    = (state_q == ST_LOCKED) && track_en && q_valid && !word_match;

  always_ff @(posedge gsclk_il) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      settle_q <= '0;
      match_q  <= '0;
      slip_q   <= '0;
      align_q  <= 1'b0;
      locked_q <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      align_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_LOCKED, ST_FAIL: begin
          if (start_ok) begin
            state_q  <= ST_SETTLE;
            settle_q <= '0;
            match_q  <= '0;
            slip_q   <= '0;
            locked_q <= 1'b0;
            fail_q   <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (settle_q == SETTLE_LAST) begin
            settle_q <= '0;
            state_q  <= ST_CHECK;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        ST_CHECK: begin
          if (q_valid) begin
            if (word_match) begin
              if (match_q == MATCH_LAST) begin
                match_q  <= '0;
                locked_q <= 1'b1;
                state_q  <= ST_LOCKED;
              end else begin
                match_q <= match_q + 1'b1;
              end
            end else begin
              match_q <= '0;
              if (slip_q == SLIP_LAST) begin
                fail_q  <= 1'b1;
                state_q <= ST_FAIL;
              end else begin
                // align_q is high for exactly the one cycle spent in SLIP.
                align_q <= 1'b1;
                state_q <= ST_SLIP;
              end
            end
          end
        end
        ST_SLIP: begin
          slip_q  <= slip_q + 1'b1;
          state_q <= ST_SETTLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  ddr_sat_counter #(
    .W(ERR_W)
  ) u_err_cnt (
    .clk  (gsclk_il),
    .rst  (rst),
    .clr_i(start_ok),
    .inc_i(err_inc),
    .cnt_o(err_cnt)
  );

  assign busy     = state_q inside {ST_SETTLE, ST_CHECK, ST_SLIP};
  assign align_il = align_q;
  assign locked   = locked_q;
  assign fail     = fail_q;
  assign slip_cnt = slip_q;

endmodule

// File: tb/tb_ddr_rd_bitslip_ctrl.sv
// Randomized bench for ddr_rd_bitslip_ctrl against an edge-timeline model of the alignment rules.
module tb_ddr_rd_bitslip_ctrl;

  localparam logic [7:0] PAT    = 8'h0F;
  localparam int         SETTLE = 8;
  localparam int         MATCH  = 16;
  localparam int         MAXS   = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] q;
  logic       q_valid;
  logic       track_en;
  logic       align_il;
  logic       busy;
  logic       locked;
  logic       fail;
  logic [2:0] slip_cnt;
  logic [7:0] err_cnt;

  int checks = 0;
  int errors = 0;

  ddr_rd_bitslip_ctrl dut (
    .gsclk_il(clk),
    .rst     (rst),
    .start   (start),
    .q       (q),
    .q_valid (q_valid),
    .track_en(track_en),
    .align_il(align_il),
    .busy    (busy),
    .locked  (locked),
    .fail    (fail),
    .slip_cnt(slip_cnt),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
    int r;
    r = s % 8;
    if (r == 0) return v;
    return (v << r) | (v >> (8 - r));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One alignment run. The IO model shows the pattern rotated by 'mis' positions;
  // each observed align_il pulse removes one position of rotation (when rot_en).
  task automatic run_align(input string name, input int mis0, input bit rot_en,
                           input int valid_pct, input int inject_at, input bit always_bad,
                           input bit exp_lock, input int exp_slips, input int exp_lock_edge);
    int mis, win, run, slips, exp_slip, pulses, last_pulse, lock_seen;
    bit done, exp_locked, exp_fail, exp_pulse, injected, pend_slip, sample_ok, bad_now;
    logic [7:0] qv;
    mis = mis0; win = SETTLE + 1; run = 0; slips = 0; exp_slip = 0;
    pulses = 0; last_pulse = -100; lock_seen = -1;
    done = 0; exp_locked = 0; exp_fail = 0; injected = 0; pend_slip = 0;
    for (int n = 0; n < 3000; n++) begin
      start     = (n == 0);
      q_valid   = ($urandom_range(99) < valid_pct);
      sample_ok = !done && (n >= win) && q_valid;
      bad_now   = sample_ok && (inject_at > 0) && !injected && (run == inject_at - 1);
      if (always_bad) qv = 8'hFF;
      else if (bad_now) begin qv = ~PAT; injected = 1; end
      else if (!sample_ok) qv = 8'($urandom);
      else qv = rotl8(PAT, mis);
      q = qv;
      exp_pulse = 0;
      if (pend_slip) begin exp_slip++; pend_slip = 0; end
      if (sample_ok) begin
        if (qv == PAT) begin
          run++;
          if (run == MATCH) begin exp_locked = 1; done = 1; end
        end else begin
          run = 0;
          if (slips == MAXS - 1) begin exp_fail = 1; done = 1; end
          else begin exp_pulse = 1; slips++; pend_slip = 1; win = n + SETTLE + 2; end
        end
      end
      tick();
      checks += 6;
      if (align_il !== exp_pulse) begin errors++; $display("FAIL %s align_il edge %0d: got %b want %b", name, n, align_il, exp_pulse); end
      if (busy !== !done) begin errors++; $display("FAIL %s busy edge %0d: got %b want %b", name, n, busy, !done); end
      if (locked !== exp_locked) begin errors++; $display("FAIL %s locked edge %0d: got %b want %b", name, n, locked, exp_locked); end
      if (fail !== exp_fail) begin errors++; $display("FAIL %s fail edge %0d: got %b want %b", name, n, fail, exp_fail); end
      if (slip_cnt !== exp_slip[2:0]) begin errors++; $display("FAIL %s slip_cnt edge %0d: got %0d want %0d", name, n, slip_cnt, exp_slip); end
      if (err_cnt !== 8'h00) begin errors++; $display("FAIL %s err_cnt edge %0d: got %0d want 0", name, n, err_cnt); end
      if (locked === 1'b1 && lock_seen < 0) lock_seen = n;
      if (align_il === 1'b1) begin
        pulses++;
        checks++;
        if (n - last_pulse <= SETTLE) begin errors++; $display("FAIL %s pulse spacing: got %0d want >%0d", name, n - last_pulse, SETTLE); end
        last_pulse = n;
        if (rot_en) mis = (mis + 7) % 8;
      end
      if (done) break;
    end
    start = 0;
    q_valid = 0;
    checks += 3;
    if (exp_lock && locked !== 1'b1) begin errors++; $display("FAIL %s final locked: got %b want 1", name, locked); end
    if (!exp_lock && fail !== 1'b1) begin errors++; $display("FAIL %s final fail: got %b want 1", name, fail); end
    if (slip_cnt !== 3'(exp_slips)) begin errors++; $display("FAIL %s final slip_cnt: got %0d want %0d", name, slip_cnt, exp_slips); end
    if (pulses != exp_slips) begin errors++; $display("FAIL %s pulse count: got %0d want %0d", name, pulses, exp_slips); end
    if (exp_lock_edge >= 0) begin
      checks++;
      if (lock_seen != exp_lock_edge) begin errors++; $display("FAIL %s lock latency: got edge %0d want %0d", name, lock_seen, exp_lock_edge); end
    end
  endtask

  task automatic check_idle(input string name);
    checks += 6;
    if (align_il !== 1'b0) begin errors++; $display("FAIL %s align_il: got %b want 0", name, align_il); end
    if (busy !== 1'b0) begin errors++; $display("FAIL %s busy: got %b want 0", name, busy); end
    if (locked !== 1'b0) begin errors++; $display("FAIL %s locked: got %b want 0", name, locked); end
    if (fail !== 1'b0) begin errors++; $display("FAIL %s fail: got %b want 0", name, fail); end
    if (slip_cnt !== 3'd0) begin errors++; $display("FAIL %s slip_cnt: got %0d want 0", name, slip_cnt); end
    if (err_cnt !== 8'd0) begin errors++; $display("FAIL %s err_cnt: got %0d want 0", name, err_cnt); end
  endtask

  task automatic test_reset();
    rst = 1; start = 0; q = 8'h00; q_valid = 0; track_en = 0;
    repeat (3) tick();
    check_idle("reset");
    rst = 0;
    repeat (4) tick();
    check_idle("post_reset_idle");
  endtask

  task automatic test_aligned();
    run_align("aligned", 0, 1, 100, 0, 0, 1, 0, SETTLE + MATCH);
  endtask

  task automatic test_rotated();
    run_align("rotated3", 3, 1, 100, 0, 0, 1, 3, -1);
  endtask

  task automatic test_never_match();
    run_align("never_match", 0, 1, 100, 0, 1, 0, MAXS - 1, -1);
    run_align("restart_after_fail", 0, 1, 100, 0, 0, 1, 0, SETTLE + MATCH);
  endtask

  task automatic test_glitch();
    run_align("glitch10", 0, 0, 50, 10, 0, 1, 1, -1);
  endtask

  task automatic test_random_runs();
    for (int k = 0; k < 4; k++) begin
      int m, pct;
      m   = $urandom_range(7);
      pct = $urandom_range(100, 30);
      run_align("random_run", m, 1, pct, 0, 0, 1, m, -1);
    end
  endtask

  task automatic test_track();
    int exp_err, bad_words;
    bit hit;
    run_align("track_prelock", 0, 1, 100, 0, 0, 1, 0, -1);
    exp_err = 0;
    track_en = 0;
    for (int n = 0; n < 40; n++) begin
      q_valid = 1; q = 8'hF0;
      tick();
      checks++;
      if (err_cnt !== 8'd0) begin errors++; $display("FAIL track_off err_cnt: got %0d want 0", err_cnt); end
    end
    track_en = 1;
    bad_words = 0;
    for (int n = 0; n < 2000 && bad_words < 300; n++) begin
      q_valid = ($urandom_range(99) < 80);
      q = ($urandom_range(99) < 20) ? PAT : 8'($urandom);
      hit = q_valid && (q != PAT);
      if (hit) begin bad_words++; if (exp_err < 255) exp_err++; end
      tick();
      checks += 3;
      if (err_cnt !== 8'(exp_err)) begin errors++; $display("FAIL track_on err_cnt: got %0d want %0d", err_cnt, exp_err); end
      if (locked !== 1'b1) begin errors++; $display("FAIL track_on locked: got %b want 1", locked); end
      if (slip_cnt !== 3'd0) begin errors++; $display("FAIL track_on slip_cnt: got %0d want 0", slip_cnt); end
    end
    checks++;
    if (err_cnt !== 8'hFF) begin errors++; $display("FAIL track_saturate err_cnt: got %0d want 255", err_cnt); end
    track_en = 0;
    repeat (10) begin
      q_valid = 1; q = 8'h00;
      tick();
      checks++;
      if (err_cnt !== 8'hFF) begin errors++; $display("FAIL track_hold err_cnt: got %0d want 255", err_cnt); end
    end
    q_valid = 0;
  endtask

  task automatic test_rst_mid_run();
    int pulses;
    pulses = 0;
    start = 1; q = 8'hFF; q_valid = 1;
    tick();
    start = 0;
    for (int n = 0; n < 100 && pulses < 2; n++) begin
      tick();
      if (align_il === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 2) begin errors++; $display("FAIL rst_mid_run wait: got %0d pulses want 2", pulses); end
    repeat (3) tick();
    rst = 1;
    tick();
    rst = 0;
    check_idle("rst_mid_run");
    repeat (12) tick();
    check_idle("rst_no_resume");
  endtask

  task automatic test_start_ignored();
    bit exp_l;
    q = PAT; q_valid = 1;
    for (int n = 0; n <= SETTLE + MATCH + 2; n++) begin
      start = (n == 0) || (n == 5) || (n == 15);
      exp_l = (n >= SETTLE + MATCH);
      tick();
      checks += 2;
      if (locked !== exp_l) begin errors++; $display("FAIL start_ignored locked edge %0d: got %b want %b", n, locked, exp_l); end
      if (busy !== !exp_l) begin errors++; $display("FAIL start_ignored busy edge %0d: got %b want %b", n, busy, !exp_l); end
    end
    start = 0; q_valid = 0;
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_rotated();
    test_never_match();
    test_glitch();
    test_track();
    test_random_runs();
    test_rst_mid_run();
    test_start_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
